// File: rtl/sr4_rx_if.sv
// Receive-side signal bundle for the SR4 serial link: serial line, read strobe,
// received word, handshake and error pulses.
interface sr4_rx_if;
    logic       w;
    logic       rd;
    logic [3:0] Q;
    logic       valid;
    logic       ferr;
    logic       perr;
    logic       ovr;
    logic       busy;

    modport slave (
        input  w,
        input  rd,
        output Q,
        output valid,
        output ferr,
        output perr,
        output ovr,
        output busy
    );

    modport master (
        output w,
        output rd,
        input  Q,
        input  valid,
        input  ferr,
        input  perr,
        input  ovr,
        input  busy
    );
endinterface

// File: rtl/sr4_rx.sv
// SR4 serial-to-parallel frame receiver: start, 4 data bits LSB first, optional
// even parity (compiled in by SR4_RX_PARITY_EN), stop; valid/read handshake.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | line idle, waiting for a 0 start bit
// S_DATA | sampling D0..D3 into the shift register, r_cnt = bit position
// S_PAR  | sampling the even-parity bit (only with SR4_RX_PARITY_EN)
// S_STOP | sampling the stop bit and deciding accept / ferr / perr / ovr
module sr4_rx (
    input  logic         clk,
    input  logic         resetn,
    sr4_rx_if.slave      bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
`ifdef SR4_RX_PARITY_EN
        S_PAR  = 2'd2,
`endif
        S_STOP = 2'd3
    } state_t;

    state_t     r_state;
    logic [1:0] r_cnt;
    logic [3:0] r_sh;
    logic [3:0] r_q;
    logic       r_valid;
    logic       r_ferr;
    logic       r_ovr;
    logic       r_busy;

    logic       w_par_bad;
    logic       w_hold_full;

`ifdef SR4_RX_PARITY_EN
    logic       r_par;
    logic       r_perr;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign w_par_bad = ^{r_sh, r_par};
`else
    assign w_par_bad = 1'b0;
`endif

    // An unread word that the consumer is not reading on this edge blocks a new one.
    assign w_hold_full = r_valid & ~bus.rd;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_sh    <= 4'd0;
            r_q     <= 4'd0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
            r_busy  <= 1'b0;
`ifdef SR4_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
`ifdef SR4_RX_PARITY_EN
            r_perr <= 1'b0;
`endif
            // A read retires the word; an acceptance below overrides this.
            if (r_valid && bus.rd) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (!bus.w) begin
                        r_state <= S_DATA;
                        r_cnt   <= 2'd0;
                        r_busy  <= 1'b1;
                    end
                end

                S_DATA: begin
                    r_sh[r_cnt] <= bus.w;
                    r_cnt       <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
`ifdef SR4_RX_PARITY_EN
                        r_state <= S_PAR;
`else
                        r_state <= S_STOP;
`endif
                    end
                end

`ifdef SR4_RX_PARITY_EN
                S_PAR: begin
                    r_par   <= bus.w;
                    r_state <= S_STOP;
                end
`endif

                S_STOP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (!bus.w) begin
                        r_ferr <= 1'b1;
                    end else if (w_par_bad) begin
`ifdef SR4_RX_PARITY_EN
                        r_perr <= 1'b1;
`endif
                    end else if (w_hold_full) begin
                        r_ovr <= 1'b1;
                    end else begin
                        r_q     <= r_sh;
                        r_valid <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Q     = r_q;
    assign bus.valid = r_valid;
    assign bus.ferr  = r_ferr;
    assign bus.ovr   = r_ovr;
    assign bus.busy  = r_busy;
`ifdef SR4_RX_PARITY_EN
    assign bus.perr  = r_perr;
`else
    assign bus.perr  = 1'b0;
`endif

endmodule

// File: tb/tb_sr4_rx.sv
// Directed bench for sr4_rx; parity cases are built when SR4_RX_PARITY_EN is defined.
module tb_sr4_rx;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_errors;

    sr4_rx_if u_if ();

    sr4_rx u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SR4_RX_PARITY_EN
    logic par_flip;
`endif

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] q, input logic v,
                           input logic fe, input logic pe, input logic ov);
        chk({tag, ".Q"},     {4'd0, u_if.Q}, {4'd0, q});
        chk({tag, ".valid"}, {7'd0, u_if.valid}, {7'd0, v});
        chk({tag, ".ferr"},  {7'd0, u_if.ferr},  {7'd0, fe});
        chk({tag, ".perr"},  {7'd0, u_if.perr},  {7'd0, pe});
        chk({tag, ".ovr"},   {7'd0, u_if.ovr},   {7'd0, ov});
    endtask

    // Drives one complete frame; returns just after the stop-sampling edge.
    task automatic send_frame(input logic [3:0] d, input logic stop_b, input logic rd_stop);
        u_if.w = 1'b0;
        tick;
        chk("busy_start", {7'd0, u_if.busy}, 8'd1);
        for (int i = 0; i < 4; i++) begin
            u_if.w = d[i];
            tick;
        end
`ifdef SR4_RX_PARITY_EN
        u_if.w = (^d) ^ par_flip;
        tick;
`endif
        chk("busy_pre_stop", {7'd0, u_if.busy}, 8'd1);
        u_if.w  = stop_b;
        u_if.rd = rd_stop;
        tick;
        u_if.w  = 1'b1;
        u_if.rd = 1'b0;
        chk("busy_end", {7'd0, u_if.busy}, 8'd0);
    endtask

    task automatic read_word;
        u_if.rd = 1'b1;
        tick;
        u_if.rd = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
`ifdef SR4_RX_PARITY_EN
        par_flip = 1'b0;
`endif
        resetn  = 1'b0;
        u_if.w  = 1'b1;
        u_if.rd = 1'b0;
        #1;
        chk_out("reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.busy", {7'd0, u_if.busy}, 8'd0);
        tick;
        tick;
        resetn = 1'b1;

        // Idle line: nothing may start.
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("idle.busy", {7'd0, u_if.busy}, 8'd0);
            chk("idle.valid", {7'd0, u_if.valid}, 8'd0);
        end
        chk_out("idle_end", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single good frame, then read it.
        send_frame(4'h2, 1'b1, 1'b0);
        chk_out("f2", 4'h2, 1'b1, 1'b0, 1'b0, 1'b0);
        read_word;
        chk_out("f2_rd", 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Framing error: Q kept, one-cycle ferr.
        send_frame(4'hA, 1'b0, 1'b0);
        chk_out("fA_ferr", 4'h2, 1'b0, 1'b1, 1'b0, 1'b0);
        tick;
        chk_out("fA_after", 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fA_idle", {7'd0, u_if.busy}, 8'd0);

        // Back-to-back with no read: second frame overruns.
        send_frame(4'h3, 1'b1, 1'b0);
        chk_out("f3", 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(4'h5, 1'b1, 1'b0);
        chk_out("f5_ovr", 4'h3, 1'b1, 1'b0, 1'b0, 1'b1);
        tick;
        chk_out("f5_after", 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);

        // Read on the accepting edge: new word wins, valid stays 1.
        read_word;
        chk_out("clr", 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(4'h3, 1'b1, 1'b0);
        send_frame(4'h5, 1'b1, 1'b1);
        chk_out("f5_rd", 4'h5, 1'b1, 1'b0, 1'b0, 1'b0);

        // Read coinciding with a framing error still retires the word.
        send_frame(4'h9, 1'b0, 1'b1);
        chk_out("ferr_rd", 4'h5, 1'b0, 1'b1, 1'b0, 1'b0);
        tick;

        // rd while nothing is valid is ignored; the next frame loads normally.
        read_word;
        chk_out("rd_empty", 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(4'hE, 1'b1, 1'b0);
        chk_out("fE", 4'hE, 1'b1, 1'b0, 1'b0, 1'b0);
        read_word;

`ifdef SR4_RX_PARITY_EN
        par_flip = 1'b0;
        send_frame(4'h7, 1'b1, 1'b0);
        chk_out("p7_ok", 4'h7, 1'b1, 1'b0, 1'b0, 1'b0);
        read_word;
        par_flip = 1'b1;
        send_frame(4'h7, 1'b1, 1'b0);
        chk_out("p7_bad", 4'h7, 1'b0, 1'b0, 1'b1, 1'b0);
        tick;
        chk_out("p7_after", 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
        // Bad stop outranks bad parity.
        send_frame(4'h1, 1'b0, 1'b0);
        chk_out("p_ferr_prio", 4'h7, 1'b0, 1'b1, 1'b0, 1'b0);
        tick;
        par_flip = 1'b0;
`endif

        // Mid-frame reset: leave a word valid, start a frame, reset after D1.
        send_frame(4'h6, 1'b1, 1'b0);
        chk_out("f6", 4'h6, 1'b1, 1'b0, 1'b0, 1'b0);
        u_if.w = 1'b0;
        tick;
        u_if.w = 1'b1;
        tick;
        u_if.w = 1'b1;
        tick;
        resetn = 1'b0;
        #1;
        chk_out("midrst", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst.busy", {7'd0, u_if.busy}, 8'd0);
        tick;
        resetn = 1'b1;
        tick;
        chk("post_rst.busy", {7'd0, u_if.busy}, 8'd0);
        send_frame(4'hC, 1'b1, 1'b0);
        chk_out("fC", 4'hC, 1'b1, 1'b0, 1'b0, 1'b0);
        tick;
        chk_out("fC_after", 4'hC, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
